// File: rtl/bcd_tens_recomplement.sv
// Serial recomplement stage for a 10's-complement BCD subtractor.
// It converts a raw difference plus the end carry into a sign-magnitude
// BCD result. Digits are processed one per clock, least significant first.
// A word with no end carry (a negative result) is 9's-complemented with a
// +1 rippled in. A word with the end carry set passes through with the same
// latency as a negative word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high; waiting for a word
// CONV  | one digit per clock, LSD first; DIGITS cycles
// DONE  | out_valid high; result held until out_ready
module bcd_tens_recomplement #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] in_data,
   input  logic                in_carry,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_mag,
   output logic                out_neg,
   output logic                out_err
);

   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [W-1:0]     data_q;
   logic             carry_q;
   logic             rc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     mag_q;
   logic             neg_q;
   logic             err_q;

   logic [3:0]       dig;
   logic [4:0]       t;
   logic [3:0]       res;
   logic             rc_d;
   logic             dig_err;
   logic             err_any;
   logic [W-1:0]     mag_shift;
   logic [W-1:0]     data_shift;

   // Recomplement the digit at the bottom of the shifting input word.
   // The result digit enters at the top of the magnitude register, so after
   // DIGITS shifts every digit is back in its original position.
   always_comb begin
      dig     = data_q[3:0];
      t       = 5'd9 - {1'b0, dig} + {4'd0, rc_q};
      res     = 4'd0;
      rc_d    = rc_q;
      dig_err = 1'b0;
      if (dig > 4'd9) begin
         dig_err = 1'b1;
      end else if (carry_q) begin
         res = dig;
      end else if (t == 5'd10) begin
         res  = 4'd0;
         rc_d = 1'b1;
      end else begin
         res  = t[3:0];
         rc_d = 1'b0;
      end
      err_any    = err_q | dig_err;
      mag_shift  = (mag_q >> 4) | (W'(res) << (W - 4));
      data_shift = data_q >> 4;
   end

   // Control FSM and registered outputs. On the last digit the sign is
   // qualified with a non-zero magnitude, so the block never reports a
   // negative zero. An invalid digit forces a clean zero result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         carry_q     <= 1'b0;
         rc_q        <= 1'b0;
         cnt_q       <= '0;
         mag_q       <= '0;
         neg_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q     <= in_data;
                  carry_q    <= in_carry;
                  rc_q       <= 1'b1;
                  cnt_q      <= '0;
                  err_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               data_q <= data_shift;
               rc_q   <= rc_d;
               err_q  <= err_any;
               mag_q  <= mag_shift;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  if (err_any) begin
                     mag_q <= '0;
                     neg_q <= 1'b0;
                  end else begin
                     neg_q <= !carry_q && (|mag_shift);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_mag   = mag_q;
   assign out_neg   = neg_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_tens_recomplement.sv
// Bench for bcd_tens_recomplement. The expected result is computed with
// plain integer arithmetic (10^N - value) and pushed to a queue when a word
// is issued. A monitor pops that queue and compares each result the DUT
// hands off. Inputs change 1 time unit after the rising edge, and the
// monitor samples on the falling edge.
module tb_bcd_tens_recomplement;

   localparam int D = 4;
   localparam int W = 4 * D;

   typedef struct packed {
      logic [W-1:0] mag;
      logic         neg;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_carry = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_mag;
   logic         out_neg;
   logic         out_err;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_pushed = 0;
   int   n_popped = 0;
   exp_t sb_q[$];
   exp_t last_exp;

   bcd_tens_recomplement #(.DIGITS(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mag   (out_mag),
      .out_neg   (out_neg),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] d, input logic c);
      exp_t    e;
      longint  val;
      longint  p;
      longint  mv;
      int      dg;
      e   = '0;
      val = 0;
      p   = 1;
      for (int i = 0; i < D; i++) begin
         dg = int'(d[4*i +: 4]);
         if (dg > 9) e.err = 1'b1;
         val += longint'(dg) * p;
         p   *= 10;
      end
      if (e.err) return e;
      if (c) begin
         mv = val;
      end else begin
         mv    = (p - val) % p;
         e.neg = (mv != 0);
      end
      for (int i = 0; i < D; i++) begin
         e.mag[4*i +: 4] = 4'(mv % 10);
         mv = mv / 10;
      end
      return e;
   endfunction

   // Scoreboard monitor: one pop per handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'(out_mag), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_popped++;
            chk("out_mag", 32'(out_mag), 32'(e.mag));
            chk("out_neg", 32'(out_neg), 32'(e.neg));
            chk("out_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   // Issue one word, then wait for out_valid and check the latency.
   // With spam set, in_valid stays high with junk data during conversion.
   task automatic send(input logic [W-1:0] d, input logic c, input bit spam);
      int guard;
      int lat;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_carry = c;
      last_exp = model(d, c);
      sb_q.push_back(last_exp);
      n_pushed++;
      @(posedge clk); #1;
      in_valid = spam;
      in_data  = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         if (spam) chk("in_ready_conv", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(D));
      in_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < D; i++)
         w[4*i +: 4] = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 15));
      return w;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_mag", 32'(out_mag), 32'd0);
      chk("rst_out_neg", 32'(out_neg), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed words.
      out_ready = 1'b1;
      send(16'h9753, 1'b0, 1'b0);
      send(16'h1234, 1'b1, 1'b0);
      send(16'h0000, 1'b0, 1'b0);
      send(16'h12A4, 1'b0, 1'b0);
      send(16'h0000, 1'b1, 1'b0);
      send(16'h9999, 1'b0, 1'b0);
      send(16'hF999, 1'b1, 1'b0);

      // Backpressure, with in_valid pulsed through CONV and DONE.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(16'h5001, 1'b0, 1'b1);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = W'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_mag_hold", 32'(out_mag), 32'(last_exp.mag));
         chk("bp_neg_hold", 32'(out_neg), 32'(last_exp.neg));
         chk("bp_err_hold", 32'(out_err), 32'(last_exp.err));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_in_ready_pre_release", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("post_release_in_ready", 32'(in_ready), 32'd1);
      chk("post_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a conversion.
      in_valid = 1'b1;
      in_data  = 16'h4321;
      in_carry = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_mag", 32'(out_mag), 32'd0);
      chk("midrst_out_neg", 32'(out_neg), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_rst_in_ready", 32'(in_ready), 32'd1);
      send(16'h0001, 1'b0, 1'b0);

      // Randomized words with random backpressure.
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         out_ready = $urandom_range(0, 1) != 0;
         send(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            chk("rand_hold_mag", 32'(out_mag), 32'(last_exp.mag));
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      chk("results_count", 32'(n_popped), 32'(n_pushed));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
